// File: rtl/score_display.sv
// N-digit BCD score counter with persistent high score, driving a multiplexed
// 7-segment display (one shared segment bus, one-hot digit select).
module score_display #(
    parameter int DIGITS        = 2,
    parameter int DWELL_CYCLES  = 1,
    parameter bit BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  wrap_mode,
    input  logic                  ena,
    input  logic                  invert,
    output logic [DIGITS*4-1:0]   score,
    output logic [DIGITS*4-1:0]   high_score,
    output logic                  new_high,
    output logic                  overflow,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digits
);

    localparam int                W          = DIGITS * 4;
    localparam int                IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [15:0]       DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [W-1:0]      NINES      = {DIGITS{4'h9}};

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [W-1:0]      score_q, high_q, score_d;
    logic              new_high_q, overflow_q, ovf_d, high_up;
    logic [15:0]       dwell_q;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        cur_digit;
    logic              lead_blank, upper_zero;
    logic [6:0]        seg_p0, segments_q;
    logic [DIGITS-1:0] sel_p0, digits_q;

    // Score command decode; BCD values compare correctly as plain unsigned.
    always_comb begin
        score_d = score_q;
        ovf_d   = 1'b0;
        if (clear) begin
            score_d = '0;
        end else if (inc ^ dec) begin
            if (inc) begin
                if (score_q == NINES) begin
                    ovf_d = 1'b1;
                    if (wrap_mode) score_d = '0;
                end else begin
                    score_d = bcd_inc(score_q);
                end
            end else begin
                if (score_q == '0) begin
                    ovf_d = 1'b1;
                    if (wrap_mode) score_d = NINES;
                end else begin
                    score_d = bcd_dec(score_q);
                end
            end
        end
        high_up = (score_d > high_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            score_q    <= score_d;
            overflow_q <= ovf_d;
            new_high_q <= high_up;
            if (high_up) high_q <= score_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q <= '0;
            idx_q   <= '0;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            dwell_q <= dwell_q + 16'd1;
        end
    end

    // Stage p0: select active digit, apply blanking and polarity.
    always_comb begin
        cur_digit  = score_q[3:0];
        lead_blank = 1'b0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (score_q[i*4 +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_digit  = score_q[i*4 +: 4];
                lead_blank = BLANK_LEADING && (i > 0) && upper_zero;
            end
        end
        seg_p0 = (!ena || lead_blank) ? 7'd0 : seg_decode(cur_digit);
        sel_p0 = DIGITS'(1) << idx_q;
        if (invert) begin
            seg_p0 = ~seg_p0;
            sel_p0 = ~sel_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segments_q <= invert ? 7'h7F : 7'h00;
            digits_q   <= invert ? '1 : '0;
        end else begin
            segments_q <= seg_p0;
            digits_q   <= sel_p0;
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;
    assign overflow   = overflow_q;
    assign segments   = segments_q;
    assign digits     = digits_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench: a 2-digit/dwell-1 instance for counting and a 3-digit/dwell-4 instance for scanning.
module tb_score_display;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_clear = 0, a_inc = 0, a_dec = 0, a_wrap = 0, a_ena = 1, a_inv = 0;
    logic [7:0] a_score, a_high;
    logic       a_nh, a_ovf;
    logic [6:0] a_seg;
    logic [1:0] a_dig;

    logic        b_clear = 0, b_inc = 0, b_dec = 0, b_wrap = 0, b_ena = 1, b_inv = 0;
    logic [11:0] b_score, b_high;
    logic        b_nh, b_ovf;
    logic [6:0]  b_seg;
    logic [2:0]  b_dig;

    score_display #(.DIGITS(2), .DWELL_CYCLES(1), .BLANK_LEADING(1)) u_a (
        .clk(clk), .rst(rst), .clear(a_clear), .inc(a_inc), .dec(a_dec),
        .wrap_mode(a_wrap), .ena(a_ena), .invert(a_inv),
        .score(a_score), .high_score(a_high), .new_high(a_nh), .overflow(a_ovf),
        .segments(a_seg), .digits(a_dig)
    );

    score_display #(.DIGITS(3), .DWELL_CYCLES(4), .BLANK_LEADING(1)) u_b (
        .clk(clk), .rst(rst), .clear(b_clear), .inc(b_inc), .dec(b_dec),
        .wrap_mode(b_wrap), .ena(b_ena), .invert(b_inv),
        .score(b_score), .high_score(b_high), .new_high(b_nh), .overflow(b_ovf),
        .segments(b_seg), .digits(b_dig)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          pulses, ovfs, units;
        int          idx;
        logic [2:0]  exp_dig;

        // Reset state
        step(); step();
        chk("rst_a_score", a_score, 8'h00);
        chk("rst_a_high", a_high, 8'h00);
        chk("rst_a_nh", a_nh, 1'b0);
        chk("rst_a_ovf", a_ovf, 1'b0);
        chk("rst_a_seg", a_seg, 7'h00);
        chk("rst_a_dig", a_dig, 2'b00);
        chk("rst_b_dig", b_dig, 3'b000);
        chk("rst_b_seg", b_seg, 7'h00);
        rst = 0;

        // Scan and dwell, non-inverted, score 0
        for (int e = 1; e <= 24; e++) begin
            step();
            idx     = ((e - 1) / 4) % 3;
            exp_dig = 3'b001 << idx;
            chk("scan_dig", b_dig, exp_dig);
            chk("scan_seg", b_seg, (idx == 0) ? 7'h3F : 7'h00);
        end

        // Inverted scan, restarted by reset
        b_inv = 1; rst = 1;
        step();
        chk("rst_inv_dig", b_dig, 3'b111);
        chk("rst_inv_seg", b_seg, 7'h7F);
        rst = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            idx     = ((e - 1) / 4) % 3;
            exp_dig = ~(3'b001 << idx);
            chk("inv_dig", b_dig, exp_dig);
            chk("inv_seg", b_seg, (idx == 0) ? 7'h40 : 7'h7F);
        end
        b_inv = 0;

        // Leading-zero blanking at 0x007
        b_inc = 1;
        repeat (7) step();
        b_inc = 0;
        step();
        chk("blank_score", b_score, 12'h007);
        units = 0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (b_dig == 3'b001) begin
                units++;
                chk("blank_units", b_seg, 7'h07);
            end else begin
                chk("blank_upper", b_seg, 7'h00);
            end
        end
        chk("blank_units_dwell", units, 4);

        // Display disable keeps scanning
        b_ena = 0;
        step();
        for (int e = 0; e < 12; e++) begin
            step();
            chk("ena_seg", b_seg, 7'h00);
            chk("ena_onehot", $onehot(b_dig), 1'b1);
        end
        b_ena = 1;

        // Reset mid-operation at 0x35 with inc held
        b_inc = 1;
        repeat (28) step();
        chk("mid_score", b_score, 12'h035);
        chk("mid_high", b_high, 12'h035);
        rst = 1;
        step();
        chk("midrst_score", b_score, 12'h000);
        chk("midrst_high", b_high, 12'h000);
        chk("midrst_seg", b_seg, 7'h00);
        chk("midrst_dig", b_dig, 3'b000);
        rst = 0; b_inc = 0;
        step();
        chk("midrst_restart", b_dig, 3'b001);

        // Counting with carry to 0x99, then wrap
        a_wrap = 1; a_inc = 1;
        pulses = 0; ovfs = 0;
        for (int e = 0; e < 99; e++) begin
            step();
            if (a_nh) pulses++;
            if (a_ovf) ovfs++;
        end
        chk("count_score", a_score, 8'h99);
        chk("count_nh_pulses", pulses, 99);
        chk("count_no_ovf", ovfs, 0);
        step();
        chk("wrap_inc_score", a_score, 8'h00);
        chk("wrap_inc_ovf", a_ovf, 1'b1);
        chk("wrap_inc_nh", a_nh, 1'b0);
        chk("wrap_inc_high", a_high, 8'h99);
        a_inc = 0;
        step();
        chk("ovf_one_cycle", a_ovf, 1'b0);

        // Saturation and decrement wrap
        a_dec = 1;
        step();
        chk("wrap_dec_score", a_score, 8'h99);
        chk("wrap_dec_ovf", a_ovf, 1'b1);
        a_dec = 0; a_wrap = 0; a_inc = 1;
        step();
        chk("sat_inc_score", a_score, 8'h99);
        chk("sat_inc_ovf", a_ovf, 1'b1);
        a_inc = 0; a_clear = 1;
        step();
        chk("clear_score", a_score, 8'h00);
        chk("clear_keep_high", a_high, 8'h99);
        a_clear = 0; a_dec = 1;
        step();
        chk("sat_dec_score", a_score, 8'h00);
        chk("sat_dec_ovf", a_ovf, 1'b1);
        a_dec = 0;

        // Priority and high score persistence
        rst = 1;
        step();
        rst = 0; a_inc = 1;
        repeat (42) step();
        chk("prio_pre", a_score, 8'h42);
        a_dec = 1;
        step();
        chk("incdec_score", a_score, 8'h42);
        chk("incdec_ovf", a_ovf, 1'b0);
        chk("incdec_nh", a_nh, 1'b0);
        a_dec = 0; a_clear = 1;
        step();
        chk("clearinc_score", a_score, 8'h00);
        a_clear = 0;
        repeat (57) step();
        chk("reach57_high", a_high, 8'h57);
        a_inc = 0; a_clear = 1;
        step();
        chk("clear57_score", a_score, 8'h00);
        chk("clear57_high", a_high, 8'h57);
        a_clear = 0; a_inc = 1;
        pulses = 0;
        for (int e = 0; e < 57; e++) begin
            step();
            if (a_nh) pulses++;
        end
        chk("renew_no_nh", pulses, 0);
        chk("renew_score57", a_score, 8'h57);
        step();
        chk("renew_nh58", a_nh, 1'b1);
        chk("renew_high58", a_high, 8'h58);
        a_inc = 0;
        step();
        chk("renew_nh_one_cycle", a_nh, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Parametrised multi-digit BCD score counter with a multiplexed 7-segment driver, the next generation of the two-digit game score block. It holds an N-digit decimal score with increment, decrement and clear, wrap or saturate at the limits, and a persistent high score with new-record and overflow pulses. It scans the digits onto one shared segment bus with configurable dwell time, optional leading-zero blanking and polarity inversion. It sits beside the game controller and drives the board's common-anode or common-cathode display directly.

## Interface
Parameters:
- `DIGITS`, default 2: number of decimal digits, legal range 1..8.
- `DWELL_CYCLES`, default 1: clocks each digit stays selected, legal range 1..65535.
- `BLANK_LEADING`, default 1: when 1, leading zeros are blanked.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `clear` input 1: zeroes the score on the next edge; high score is kept.
- `inc` input 1: adds 1 to the score.
- `dec` input 1: subtracts 1 from the score.
- `wrap_mode` input 1: 1 selects wrap at the limits, 0 selects saturate.
- `ena` input 1: display enable; 0 blanks all segments while scanning continues.
- `invert` input 1: 1 inverts segment and digit-select polarity for common-anode parts.
- `score` output DIGITS*4: current BCD score, digit 0 (units) in bits [3:0].
- `high_score` output DIGITS*4: highest score reached since `rst`.
- `new_high` output 1: one-cycle pulse when `high_score` updates.
- `overflow` output 1: one-cycle pulse when an inc/dec hits a limit.
- `segments` output 7: registered segments {g,f,e,d,c,b,a}.
- `digits` output DIGITS: registered one-hot digit select; bit 0 is the units digit.

## Operation
- Command priority on each edge:
  - `clear`;
  - then `inc` and `dec` together, which is no change and no pulses;
  - then `inc`;
  - then `dec`.
- Arithmetic is pure BCD with a full ripple carry/borrow across all DIGITS in one cycle. Each score nibble stays in 0..9 at all times.
- Increment at all-9s:
  - `wrap_mode`=1 gives 0;
  - `wrap_mode`=0 holds the value;
  - `overflow` pulses in both cases.
- Decrement at 0:
  - `wrap_mode`=1 gives all-9s;
  - `wrap_mode`=0 holds 0;
  - `overflow` pulses in both cases.
- High score:
  - When the next score is numerically greater than `high_score`, `high_score` takes it on the same edge as `score` and `new_high` pulses on that edge.
  - `clear` and decrements never lower `high_score`. Only `rst` does.
- Scan:
  - A dwell counter runs 0..DWELL_CYCLES-1.
  - When it reaches DWELL_CYCLES-1 it returns to 0 and the active index advances. The index wraps from DIGITS-1 to 0.
  - With DIGITS=1 the index stays at 0.
- Digit select: `digits` is the one-hot of the active index, bitwise inverted when `invert`=1.
- Segment code, non-inverted, for digits 0..9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111. The pattern is bitwise inverted when `invert`=1.
- Blank means all segments off: 0000000, or 1111111 when inverted. The displayed digit is blank when either:
  - `ena`=0; or
  - `BLANK_LEADING`=1, the active index is >0, and that digit and all higher digits are zero.
- The units digit is never leading-blanked.

## Timing
- Reset values:
  - `score`=0, `high_score`=0, `new_high`=0, `overflow`=0;
  - active index 0, dwell counter 0;
  - `segments`=blank for the current `invert`;
  - `digits`=all deselected, which is all 0, or all 1 when `invert`=1.
- `rst` overrides every command in the same cycle.
- Score latency: a command sampled at edge k is visible on `score`, `high_score`, `new_high` and `overflow` after edge k.
- Display latency:
  - `segments` and `digits` are registered from the active index and score held before edge k, so they change together after edge k.
  - A new score reaches the display one cycle after `score` updates, on the next edge where that digit is active.
- `invert` and `ena` changes take effect at the next edge. There is no glitch between `segments` and `digits`, since both come from the same register stage.
- The first cycle after `rst` releases selects digit 0.
- Refresh period is DIGITS*DWELL_CYCLES clocks.

## Test plan
- Counting with carry: DIGITS=2, apply 99 single `inc` pulses → `score`=0x99 with no `overflow`. One more with `wrap_mode`=1 → `score`=0x00 and `overflow`=1 for one cycle. `high_score` stays 0x99.
- Saturation: at 0x99 with `wrap_mode`=0, apply `inc` → `score` stays 0x99 and `overflow` pulses. At 0x00, apply `dec` → stays 0x00 and `overflow` pulses. With `wrap_mode`=1, `dec` at 0x00 → 0x99.
- Priority: `inc`+`dec` at score 0x42 → 0x42 with no pulses. `clear`+`inc` → 0x00. After reaching 0x57 then `clear`, `high_score` stays 0x57. A new `inc` sequence pulses `new_high` only on the step from 0x57 to 0x58.
- Scan and dwell: DIGITS=3, DWELL_CYCLES=4 → `digits` steps 001, 010, 100, each for exactly 4 clocks, and repeats every 12 clocks. With `invert`=1 the pattern is 110, 101, 011.
- Blanking: score 0x007, DIGITS=3, BLANK_LEADING=1 → hundreds and tens digits show blank and units shows 0000111. At score 0x000 the units shows 0111111. `ena`=0 → all digits blank while `digits` keeps scanning.
- Reset mid-operation: assert `rst` for one cycle with score 0x35 and `high_score` 0x35 while `inc`=1 → both read 0, `segments` is blank and `digits` is deselected after the edge. The scan restarts at digit 0.
